// File: rtl/hazard_sched_if.sv
// Hazard scheduler bus. It groups the pipeline-stage register fields that the
// scheduler observes and the control signals it returns to the stage registers.
interface hazard_sched_if #(
  parameter int CNT_W = 16
);
  logic             fwd_en;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic [3:0]       exe_src1;
  logic [3:0]       exe_src2;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic             exe_br_taken;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             mem_r_en;
  logic             mem_w_en;
  logic [3:0]       wb_dest;
  logic             wb_wb_en;
  logic [1:0]       fu_sel_src1;
  logic [1:0]       fu_sel_src2;
  logic             stall;
  logic             flush_ifid;
  logic             flush_idex;
  logic             freeze;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] freeze_count;

  // Pipeline side: drives the stage fields and consumes the control outputs.
  modport master (
    output fwd_en, id_src1, id_src2, id_two_src, exe_src1, exe_src2, exe_dest,
           exe_wb_en, exe_mem_r_en, exe_br_taken, mem_dest, mem_wb_en, mem_r_en,
           mem_w_en, wb_dest, wb_wb_en,
    input  fu_sel_src1, fu_sel_src2, stall, flush_ifid, flush_idex, freeze,
           stall_count, freeze_count
  );

  // Scheduler side.
  modport slave (
    input  fwd_en, id_src1, id_src2, id_two_src, exe_src1, exe_src2, exe_dest,
           exe_wb_en, exe_mem_r_en, exe_br_taken, mem_dest, mem_wb_en, mem_r_en,
           mem_w_en, wb_dest, wb_wb_en,
    output fu_sel_src1, fu_sel_src2, stall, flush_ifid, flush_idex, freeze,
           stall_count, freeze_count
  );
endinterface

// File: rtl/hazard_sched_unit.sv
// Pipeline scheduler for the 5-stage ARM core. It produces the EXE forwarding
// selects, load-use/RAW stalls with bubbles, branch flushes, and a global
// freeze that holds the pipe while a multi-cycle memory access occupies MEM.
// It also keeps saturating stall/freeze statistics. CNT_W must match the
// CNT_W of the connected interface.
module hazard_sched_unit #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_sched_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_LATENCY) + 1;
  // The first freeze cycle happens in RUN, so MEM_WAIT counts only the rest.
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    WAIT_W'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  freeze_cnt;

  logic       mem_op;
  logic       freeze_raw;
  logic       hit_e1, hit_e2, hit_m1, hit_m2;
  logic       hazard;
  logic [1:0] sel1, sel2;
  logic       stall_o, flush_ifid_o, flush_idex_o, freeze_o;

  assign mem_op = bus.mem_r_en | bus.mem_w_en;

  // Freeze starts in the same cycle the access reaches MEM and lasts
  // MEM_LATENCY-1 cycles; the release cycle in MEM_WAIT lets the pipe advance.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    freeze_raw = 1'b0;
    if (state == RUN) freeze_raw = mem_op && (MEM_LATENCY > 1);
    else              freeze_raw = (wait_cnt != '0);
  end

  // Forwarding selects: a non-load MEM result beats the WB value.
  always_comb begin
    sel1 = 2'b00;
    sel2 = 2'b00;
    if (bus.fwd_en) begin
      if (bus.mem_wb_en && !bus.mem_r_en && bus.mem_dest == bus.exe_src1) sel1 = 2'b01;
      else if (bus.wb_wb_en && bus.wb_dest == bus.exe_src1)               sel1 = 2'b10;
      if (bus.mem_wb_en && !bus.mem_r_en && bus.mem_dest == bus.exe_src2) sel2 = 2'b01;
      else if (bus.wb_wb_en && bus.wb_dest == bus.exe_src2)               sel2 = 2'b10;
    end
  end

  // RAW detection: with forwarding only a load in EXE stalls; without it any
  // pending EXE or MEM writer of a used source stalls.
  always_comb begin
    hit_e1 = bus.exe_wb_en && (bus.exe_dest == bus.id_src1);
    hit_e2 = bus.exe_wb_en && (bus.exe_dest == bus.id_src2) && bus.id_two_src;
    hit_m1 = bus.mem_wb_en && (bus.mem_dest == bus.id_src1);
    hit_m2 = bus.mem_wb_en && (bus.mem_dest == bus.id_src2) && bus.id_two_src;
    if (bus.fwd_en) hazard = bus.exe_mem_r_en && (hit_e1 || hit_e2);
    else            hazard = hit_e1 || hit_e2 || hit_m1 || hit_m2;
  end

  // Output priority: reset, then freeze, then taken branch, then hazard.
  always_comb begin
    stall_o      = 1'b0;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    freeze_o     = 1'b0;
    if (!rst) begin
      if (freeze_raw) begin
        freeze_o = 1'b1;
      end else if (bus.exe_br_taken) begin
        flush_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
      end else if (hazard) begin
        stall_o      = 1'b1;
        flush_idex_o = 1'b1;
      end
    end
  end

  // Memory-wait FSM.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_op && (MEM_LATENCY > 1)) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          else                state    <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall_o && stall_cnt != '1)   stall_cnt  <= stall_cnt + 1'b1;
      if (freeze_o && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

  assign bus.fu_sel_src1  = rst ? 2'b00 : sel1;
  assign bus.fu_sel_src2  = rst ? 2'b00 : sel2;
  assign bus.stall        = stall_o;
  assign bus.flush_ifid   = flush_ifid_o;
  assign bus.flush_idex   = flush_idex_o;
  assign bus.freeze       = freeze_o;
  assign bus.stall_count  = rst ? '0 : stall_cnt;
  assign bus.freeze_count = rst ? '0 : freeze_cnt;

endmodule
